// File: rtl/updown_counter_if.sv
// Bundle of control, status and compare signals for updown_counter.
// Snapshot signals exist only when COUNTER_SNAPSHOT_EN is defined.
interface updown_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  en;
  logic                  up;
  logic                  clr;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  sat;
  logic [PRESCALE_W-1:0] presc;
  logic [WIDTH-1:0]      cmp_val;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  match;
  logic                  ovf_sticky;
`ifdef COUNTER_SNAPSHOT_EN
  logic                  snap;
  logic [WIDTH-1:0]      snap_val;
  logic                  snap_valid;
`endif

  modport master (
    output en, up, clr, load, load_val, sat, presc, cmp_val,
`ifdef COUNTER_SNAPSHOT_EN
    output snap,
    input  snap_val, snap_valid,
`endif
    input  count, tc, match, ovf_sticky
  );

  modport slave (
    input  en, up, clr, load, load_val, sat, presc, cmp_val,
`ifdef COUNTER_SNAPSHOT_EN
    input  snap,
    output snap_val, snap_valid,
`endif
    output count, tc, match, ovf_sticky
  );
endinterface

// File: rtl/updown_counter.sv
// Synchronous up/down counter with prescaler, wrap/saturate, tc pulse, match and sticky overflow.
// Optional pre-update count snapshot when COUNTER_SNAPSHOT_EN is defined.
module updown_counter #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}},
  parameter int               PRESCALE_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] psc_cnt_reg, psc_cnt_next;
  logic [WIDTH-1:0]      count_reg, count_next;
  logic                  tc_reg, tc_next;
  logic                  ovf_reg, ovf_next;
  logic                  match_reg, match_next;
  logic [WIDTH-1:0]      load_clamped;
  logic [WIDTH-1:0]      eq_bits;
  logic                  tick, at_top, at_bottom, boundary;

  always_comb begin
    tick         = bus.en && (psc_cnt_reg >= bus.presc);
    load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    at_top       = (count_reg == MAX_VAL);
    at_bottom    = (count_reg == '0);
    boundary     = tick && (bus.up ? at_top : at_bottom);

    count_next   = count_reg;
    psc_cnt_next = psc_cnt_reg;
    tc_next      = 1'b0;
    ovf_next     = ovf_reg;

    if (bus.clr) begin
      count_next   = '0;
      psc_cnt_next = '0;
      ovf_next     = 1'b0;
    end else if (bus.load) begin
      count_next   = load_clamped;
      psc_cnt_next = '0;
    end else begin
      if (bus.en) begin
        psc_cnt_next = tick ? '0 : psc_cnt_reg + PSC_ONE;
      end
      // Bounds are detected by equality so no carry-out is ever needed.
      if (tick) begin
        if (bus.up) begin
          count_next = at_top ? (bus.sat ? MAX_VAL : '0) : count_reg + CNT_ONE;
        end else begin
          count_next = at_bottom ? (bus.sat ? '0 : MAX_VAL) : count_reg - CNT_ONE;
        end
      end
      if (boundary) begin
        tc_next  = 1'b1;
        ovf_next = 1'b1;
      end
    end
  end

  // Match is taken from the next count so it lines up with the registered count.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_eq
      assign eq_bits[gi] = ~(count_next[gi] ^ bus.cmp_val[gi]);
    end
  endgenerate
  assign match_next = &eq_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= '0;
      psc_cnt_reg <= '0;
      tc_reg      <= 1'b0;
      ovf_reg     <= 1'b0;
      match_reg   <= 1'b0;
    end else begin
      count_reg   <= count_next;
      psc_cnt_reg <= psc_cnt_next;
      tc_reg      <= tc_next;
      ovf_reg     <= ovf_next;
      match_reg   <= match_next;
    end
  end

  assign bus.count      = count_reg;
  assign bus.tc         = tc_reg;
  assign bus.match      = match_reg;
  assign bus.ovf_sticky = ovf_reg;

`ifdef COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] snap_val_reg;
  logic             snap_valid_reg;

  // Captures the pre-update count, independent of clr/load/tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_val_reg   <= '0;
      snap_valid_reg <= 1'b0;
    end else begin
      snap_valid_reg <= bus.snap;
      if (bus.snap) begin
        snap_val_reg <= count_reg;
      end
    end
  end

  assign bus.snap_val   = snap_val_reg;
  assign bus.snap_valid = snap_valid_reg;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed scenarios plus randomized stimulus
// checked every cycle against an integer-arithmetic model.
module tb_updown_counter;
  localparam int W    = 8;
  localparam int MAXV = 9;
  localparam int PW   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  updown_counter_if #(.WIDTH(W), .PRESCALE_W(PW)) u_if ();

  updown_counter #(.WIDTH(W), .MAX_VAL(W'(MAXV)), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  // Reference model state (plain integers)
  int m_count = 0, m_psc = 0, m_tc = 0, m_match = 0, m_ovf = 0;
  int m_snap_val = 0, m_snap_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_psc = 0; m_tc = 0; m_match = 0; m_ovf = 0;
      m_snap_val = 0; m_snap_valid = 0;
    end else begin
      int nxt;
      bit tk;
`ifdef COUNTER_SNAPSHOT_EN
      m_snap_valid = int'(u_if.snap);
      if (u_if.snap) m_snap_val = m_count;
`endif
      m_tc = 0;
      if (u_if.clr) begin
        m_count = 0; m_psc = 0; m_ovf = 0;
      end else if (u_if.load) begin
        m_count = (int'(u_if.load_val) > MAXV) ? MAXV : int'(u_if.load_val);
        m_psc = 0;
      end else begin
        tk = 1'b0;
        if (u_if.en) begin
          if (m_psc >= int'(u_if.presc)) begin tk = 1'b1; m_psc = 0; end
          else m_psc = m_psc + 1;
        end
        if (tk) begin
          nxt = u_if.up ? m_count + 1 : m_count - 1;
          if (nxt > MAXV || nxt < 0) begin
            m_tc = 1; m_ovf = 1;
            if (u_if.sat) nxt = (nxt < 0) ? 0 : MAXV;
            else nxt = ((nxt % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
          end
          m_count = nxt;
        end
      end
      m_match = (m_count == int'(u_if.cmp_val)) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("count", 32'(u_if.count), 32'(m_count));
      check("tc", 32'(u_if.tc), 32'(m_tc));
      check("match", 32'(u_if.match), 32'(m_match));
      check("ovf_sticky", 32'(u_if.ovf_sticky), 32'(m_ovf));
`ifdef COUNTER_SNAPSHOT_EN
      check("snap_valid", 32'(u_if.snap_valid), 32'(m_snap_valid));
      check("snap_val", 32'(u_if.snap_val), 32'(m_snap_val));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    u_if.en = 0; u_if.up = 1; u_if.clr = 0; u_if.load = 0; u_if.load_val = '0;
    u_if.sat = 0; u_if.presc = '0; u_if.cmp_val = 8'd3;
`ifdef COUNTER_SNAPSHOT_EN
    u_if.snap = 0;
`endif
    #2 rst_n = 0;
    #1 chk_on = 1'b1;
    check("reset_count", 32'(u_if.count), 0);
    check("reset_tc", 32'(u_if.tc), 0);
    step(2);
    rst_n = 1;

    // 1: wrap up-count 0..9 then 0
    u_if.en = 1; u_if.up = 1; u_if.sat = 0; u_if.presc = '0;
    step(9);
    check("wrap_at_9", 32'(u_if.count), 9);
    check("wrap_tc_low", 32'(u_if.tc), 0);
    step(1);
    check("wrap_to_0", 32'(u_if.count), 0);
    check("wrap_tc_high", 32'(u_if.tc), 1);
    check("wrap_ovf", 32'(u_if.ovf_sticky), 1);
    step(1);
    check("wrap_tc_one_cycle", 32'(u_if.tc), 0);

    // 3: priority clr > load, then clamp
    u_if.clr = 1; u_if.load = 1; u_if.load_val = 8'd7;
    step(1);
    check("clr_over_load", 32'(u_if.count), 0);
    check("clr_ovf", 32'(u_if.ovf_sticky), 0);
    u_if.clr = 0; u_if.load_val = 8'd200;
    step(1);
    check("load_clamp", 32'(u_if.count), 9);

    // 2: saturating down-count with prescaler 3
    u_if.load_val = 8'd2; u_if.presc = 4'd3; u_if.up = 0; u_if.sat = 1;
    step(1);
    u_if.load = 0;
    check("sat_load2", 32'(u_if.count), 2);
    step(3);
    check("sat_hold2", 32'(u_if.count), 2);
    step(1);
    check("sat_at1", 32'(u_if.count), 1);
    step(4);
    check("sat_at0", 32'(u_if.count), 0);
    step(4);
    check("sat_tc", 32'(u_if.tc), 1);
    check("sat_hold0", 32'(u_if.count), 0);
    step(4);
    check("sat_tc_again", 32'(u_if.tc), 1);

    // 4: enable gating with match on 5
    u_if.clr = 1; step(1); u_if.clr = 0;
    u_if.cmp_val = 8'd5; u_if.presc = 4'd1; u_if.up = 1; u_if.sat = 0;
    for (int i = 0; i < 12; i++) begin
      u_if.en = ~u_if.en;
      step(3);
    end

    // 5: async reset mid-count
    u_if.en = 0; u_if.cmp_val = 8'd6; u_if.load_val = 8'd6; u_if.load = 1;
    step(1);
    u_if.load = 0;
    step(1);
    check("pre_reset_match", 32'(u_if.match), 1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("async_count", 32'(u_if.count), 0);
    check("async_match", 32'(u_if.match), 0);
    check("async_ovf", 32'(u_if.ovf_sticky), 0);
    check("async_tc", 32'(u_if.tc), 0);
    @(negedge clk); rst_n = 1; u_if.en = 1; u_if.presc = 4'd1; u_if.up = 1;
    step(1);
    check("restart_psc0", 32'(u_if.count), 0);
    step(1);
    check("restart_first_tick", 32'(u_if.count), 1);

`ifdef COUNTER_SNAPSHOT_EN
    // 6: snapshot with concurrent tick
    u_if.load_val = 8'd4; u_if.load = 1; step(1); u_if.load = 0;
    u_if.presc = '0; u_if.snap = 1;
    step(1);
    u_if.snap = 0;
    check("snap_val4", 32'(u_if.snap_val), 4);
    check("snap_valid_hi", 32'(u_if.snap_valid), 1);
    check("snap_count5", 32'(u_if.count), 5);
    step(1);
    check("snap_valid_lo", 32'(u_if.snap_valid), 0);
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      u_if.en       = ($urandom_range(0, 9) < 8);
      u_if.up       = $urandom_range(0, 1);
      u_if.sat      = ($urandom_range(0, 3) == 0);
      u_if.clr      = ($urandom_range(0, 99) == 0);
      u_if.load     = ($urandom_range(0, 29) == 0);
      u_if.load_val = W'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) u_if.presc = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  u_if.cmp_val = W'($urandom_range(0, MAXV));
`ifdef COUNTER_SNAPSHOT_EN
      u_if.snap     = ($urandom_range(0, 7) == 0);
`endif
      step(1);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Fully synchronous, parametrised up/down counter that replaces per-bit ripple counters in the design.
- All state is clocked by clk only. It adds enable, direction, synchronous clear and load, a programmable prescaler, wrap or saturate mode, terminal-count pulse, compare match and a sticky overflow flag.
- Used as a general event/time-base counter feeding status logic and output pins.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, upper count bound; counter range is 0..MAX_VAL (must be 1..2**WIDTH-1).
- PRESCALE_W, 4, prescaler width in bits (1..16).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; gates the prescaler
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value loaded on load
- sat  input  1  1 = saturate at bounds, 0 = wrap
- presc  input  PRESCALE_W  a tick occurs every presc+1 enabled cycles
- cmp_val  input  WIDTH  compare value for match
- count  output  WIDTH  current count
- tc  output  1  terminal-count pulse
- match  output  1  count equals cmp_val
- ovf_sticky  output  1  latched boundary event

Behaviour:
- Reset is asynchronous, active-low on rst_n, clock clk.
  - While rst_n = 0: count = 0, tc = 0, match = 0, ovf_sticky = 0, prescaler counter = 0, all immediately.
  - Deassertion is used synchronously; the first update happens on the first rising clk edge after release.
- Priority per edge: clr > load > tick.
  - clr: count <= 0, prescaler <= 0, ovf_sticky <= 0, tc <= 0.
  - load (no clr): count <= min(load_val, MAX_VAL), prescaler <= 0, tc <= 0. ovf_sticky is unchanged.
- Prescaler (internal psc_cnt, width PRESCALE_W):
  - With en = 1: if psc_cnt >= presc then tick = 1 and psc_cnt <= 0; else psc_cnt <= psc_cnt + 1.
  - With en = 0: psc_cnt holds and there is no tick.
  - presc = 0 gives a tick on every enabled cycle.
  - The >= compare makes lowering presc mid-count take effect without lockup.
- On tick, up = 1:
  - count < MAX_VAL: count + 1.
  - count == MAX_VAL: boundary event. Next value is 0 if sat = 0, or hold MAX_VAL if sat = 1.
- On tick, up = 0:
  - count > 0: count - 1.
  - count == 0: boundary event. Next value is MAX_VAL if sat = 0, or hold 0 if sat = 1.
- Boundary event: tc <= 1 for exactly one cycle, coincident with the post-event count value; ovf_sticky <= 1.
  - In saturate mode, every further tick at the bound is another boundary event, so tc pulses again.
- tc is 0 on every edge without a boundary event.
- match:
  - Registered from the next count value compared with cmp_val, so match is high in the same cycles count == cmp_val.
  - A cmp_val change is reflected one cycle late.
- No tick (en = 0, or prescaler not expired): count holds.
- up and sat are sampled only on tick edges. Changing them between ticks has no side effect.
- count never exceeds MAX_VAL under any input sequence.
- Arithmetic is WIDTH bits with no carry out. Boundary detection uses equality with MAX_VAL or 0, not carry.

Optional Feature:
- Macro: COUNTER_SNAPSHOT_EN.
- When defined, the block adds these ports:
  - snap, input 1.
  - snap_val, output WIDTH, reset 0.
  - snap_valid, output 1, reset 0.
- When snap = 1 at an edge: snap_val <= count as it was before that edge's update, and snap_valid pulses high for one cycle.
- snap is independent of clr, load and tick. If clr is asserted in the same cycle, the captured value is the pre-clear count.
- When not defined: the three ports and their registers are absent; all other behaviour is identical.

Test Plan:
1. Wrap up-count: WIDTH=8, MAX_VAL=9, presc=0, sat=0, up=1, en=1 for 11 cycles from 0 -> count 1..9 then 0; tc high only in the cycle count = 0; ovf_sticky = 1 afterwards.
2. Saturating down-count with prescaler: load 2, presc=3, up=0, sat=1, en=1 -> count 2,1,0, changing every 4th cycle, then holds 0; tc pulses once every 4 cycles once at 0.
3. Priority and clamp:
   - clr=1 and load=1 with load_val=7 -> count 0, ovf_sticky 0.
   - Then load 200 with MAX_VAL=9 -> count 9.
4. Enable gating and match: cmp_val=5, presc=1, toggle en every 3 cycles -> count advances only on enabled tick edges; psc_cnt holds while en=0; match high exactly while count=5.
5. Async reset mid-count: count=6, pull rst_n low between clock edges -> count, tc, match and ovf_sticky are 0 before the next edge; after release, counting restarts from 0 with psc_cnt=0.
6. (COUNTER_SNAPSHOT_EN) snap=1 at count=4 with a concurrent tick -> snap_val=4, snap_valid high for one cycle, count=5.
